// File: rtl/median_window_feed_if.sv
// Bundled sample-in / window-out handshake for median_window_feed.
// The slave modport is the window builder itself; master is the surrounding environment.
interface median_window_feed_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] a2;
  logic             out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, a0, a1, a2, out_last
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, a0, a1, a2, out_last
  );
endinterface

// File: rtl/median_window_feed.sv
// Builds 3-sample sliding windows (x[i-1], x[i], x[i+1]) per line for a median stage.
// Borders replicate the edge sample; define MEDWIN_ZERO_PAD_EN to pad with zeros instead.
module median_window_feed #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  median_window_feed_if.slave bus,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Handshake: a transfer happens on any cycle where valid && ready are both high
  // at the rising edge; once out_valid is set, a0/a1/a2/out_last hold until taken.

`ifdef MEDWIN_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAVE  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] a0_q, a0_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] a2_q, a2_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             slot_free;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] s;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign in_ready  = rst_n && slot_free && (state_q != FLUSH);
  assign accept    = bus.in_valid && in_ready;
  assign s         = bus.in_data;

  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          if (bus.in_last) begin
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            a0_d        = ZERO_PAD ? '0 : s;
            a1_d        = s;
            a2_d        = ZERO_PAD ? '0 : s;
          end else begin
            // Seeding prev with the border value lets HAVE emit the first window unchanged.
            prev_d  = ZERO_PAD ? '0 : s;
            cur_d   = s;
            state_d = HAVE;
          end
        end
      end
      HAVE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          a0_d        = prev_q;
          a1_d        = cur_q;
          a2_d        = s;
          prev_d      = cur_q;
          cur_d       = s;
          state_d     = bus.in_last ? FLUSH : HAVE;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          a0_d        = prev_q;
          a1_d        = cur_q;
          a2_d        = ZERO_PAD ? '0 : cur_q;
          state_d     = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      prev_q      <= '0;
      cur_q       <= '0;
      a0_q        <= '0;
      a1_q        <= '0;
      a2_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.a0        = a0_q;
  assign bus.a1        = a1_q;
  assign bus.a2        = a2_q;
  assign busy          = (state_q != EMPTY) || out_valid_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_median_window_feed.sv
// Directed bench for median_window_feed: line windows, borders, backpressure, reset.
// Build with MEDWIN_ZERO_PAD_EN defined to exercise the zero-padding variant instead.
module tb_median_window_feed;
  localparam int W = 8;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  int         cyc;

  logic [3*W:0] exp_q[$];
  logic [3*W:0] got_q[$];
  int           cyc_q[$];

  median_window_feed_if #(.WIDTH(W)) bus ();

  median_window_feed #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // transfer monitor: sampled mid-cycle, the transfer completes at the next rising edge
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_last, bus.a0, bus.a1, bus.a2});
      cyc_q.push_back(cyc);
    end
  end

  // driver: present one sample until accepted; returns number of cycles spent waiting
  task automatic send(input logic [W-1:0] d, input logic l, output int stalls);
    bit acc;
    acc          = 1'b0;
    stalls       = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) stalls++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout data=%0d never accepted", d);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'hEE;
    bus.in_last  = 1'b1;
  endtask

  task automatic test_reset;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'hEE;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    cyc           = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b exp 0", bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL reset_out_flags got v=%b l=%b exp 0 0", bus.out_valid, bus.out_last);
    end
    checks++;
    if ({bus.a0, bus.a1, bus.a2} !== 24'h0) begin
      errors++; $display("FAIL reset_window got %h exp 000000", {bus.a0, bus.a1, bus.a2});
    end
    checks++;
    if (busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_state got busy=%b st=%0d exp 0 0", busy, dbg_state);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready);
    end
    @(posedge clk); #1;
  endtask

`ifndef MEDWIN_ZERO_PAD_EN
  task automatic test_line;
    int st;
    int c1;
    logic [3*W:0] g;
    got_q.delete(); cyc_q.delete();
    exp_q = '{{1'b0, 8'd10, 8'd10, 8'd50}, {1'b0, 8'd10, 8'd50, 8'd20},
              {1'b0, 8'd50, 8'd20, 8'd30}, {1'b1, 8'd20, 8'd30, 8'd30}};
    bus.out_ready = 1'b1;
    send(8'd10, 1'b0, st);
    send(8'd50, 1'b0, st);
    c1 = cyc;
    send(8'd20, 1'b0, st);
    send(8'd30, 1'b1, st);
    checks++;
    if (bus.in_ready !== 1'b0 || dbg_state !== 2'd2) begin
      errors++; $display("FAIL line_flush got in_ready=%b st=%0d exp 0 2", bus.in_ready, dbg_state);
    end
    for (int k = 0; k < 50 && got_q.size() < 4; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    checks++;
    if (got_q.size() !== 4) begin
      errors++; $display("FAIL line_count got %0d exp 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        errors++; $display("FAIL line_win%0d got %h exp %h", i, g, exp_q[i]);
      end
      checks++;
      if (i < cyc_q.size() && cyc_q[i] !== c1 + i) begin
        errors++; $display("FAIL line_cycle%0d got %0d exp %0d", i, cyc_q[i], c1 + i);
      end
    end
    #1;
  endtask

  task automatic test_single;
    int st;
    got_q.delete(); cyc_q.delete();
    bus.out_ready = 1'b1;
    send(8'd77, 1'b1, st);
    checks++;
    if (dbg_state !== 2'd0 || busy !== 1'b1 || bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL single_loaded got st=%0d busy=%b v=%b exp 0 1 1", dbg_state, busy, bus.out_valid);
    end
    checks++;
    if ({bus.out_last, bus.a0, bus.a1, bus.a2} !== {1'b1, 8'd77, 8'd77, 8'd77}) begin
      errors++; $display("FAIL single_win got %h exp %h", {bus.out_last, bus.a0, bus.a1, bus.a2}, {1'b1, 8'd77, 8'd77, 8'd77});
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || got_q.size() !== 1) begin
      errors++; $display("FAIL single_done got busy=%b n=%0d exp 0 1", busy, got_q.size());
    end
  endtask

  task automatic test_backpressure;
    int st;
    logic [3*W:0] g;
    got_q.delete(); cyc_q.delete();
    exp_q = '{{1'b0, 8'd1, 8'd1, 8'd2}, {1'b0, 8'd1, 8'd2, 8'd3},
              {1'b0, 8'd2, 8'd3, 8'd4}, {1'b1, 8'd3, 8'd4, 8'd4}};
    bus.out_ready = 1'b1;
    fork
      begin
        send(8'd1, 1'b0, st);
        send(8'd2, 1'b0, st);
        send(8'd3, 1'b0, st);
        send(8'd4, 1'b1, st);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
              {bus.a0, bus.a1, bus.a2} !== {8'd1, 8'd1, 8'd2}) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b rdy=%b win=%h exp 1 0 010102", c, bus.out_valid, bus.in_ready, {bus.a0, bus.a1, bus.a2});
          end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    for (int k = 0; k < 50 && got_q.size() < 4; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() !== 4) begin
      errors++; $display("FAIL bp_count got %0d exp 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        errors++; $display("FAIL bp_win%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int s5, s6, s9;
    logic [3*W:0] g;
    got_q.delete(); cyc_q.delete();
    exp_q = '{{1'b0, 8'd5, 8'd5, 8'd6}, {1'b1, 8'd5, 8'd6, 8'd6}, {1'b1, 8'd9, 8'd9, 8'd9}};
    bus.out_ready = 1'b1;
    send(8'd5, 1'b0, s5);
    send(8'd6, 1'b1, s6);
    send(8'd9, 1'b1, s9);
    checks++;
    if (s5 !== 0 || s6 !== 0 || s9 !== 1) begin
      errors++; $display("FAIL b2b_stalls got %0d %0d %0d exp 0 0 1", s5, s6, s9);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() !== 3) begin
      errors++; $display("FAIL b2b_count got %0d exp 3", got_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        errors++; $display("FAIL b2b_win%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    int st;
    logic [3*W:0] g;
    bus.out_ready = 1'b1;
    send(8'd8, 1'b0, st);
    send(8'd9, 1'b0, st);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || {bus.a0, bus.a1, bus.a2} !== 24'h0 || busy !== 1'b0 ||
        dbg_state !== 2'd0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear got v=%b win=%h busy=%b st=%0d rdy=%b exp all 0", bus.out_valid, {bus.a0, bus.a1, bus.a2}, busy, dbg_state, bus.in_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_q.delete(); cyc_q.delete();
    exp_q = '{{1'b0, 8'd3, 8'd3, 8'd4}, {1'b1, 8'd3, 8'd4, 8'd4}};
    send(8'd3, 1'b0, st);
    send(8'd4, 1'b1, st);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() !== 2) begin
      errors++; $display("FAIL mid_reset_count got %0d exp 2", got_q.size());
    end
    for (int i = 0; i < 2; i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        errors++; $display("FAIL mid_reset_win%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
  endtask
`else
  task automatic test_zero_pad;
    int st;
    logic [3*W:0] g;
    got_q.delete(); cyc_q.delete();
    exp_q = '{{1'b0, 8'd0, 8'd10, 8'd50}, {1'b0, 8'd10, 8'd50, 8'd20}, {1'b1, 8'd50, 8'd20, 8'd0}};
    bus.out_ready = 1'b1;
    send(8'd10, 1'b0, st);
    send(8'd50, 1'b0, st);
    send(8'd20, 1'b1, st);
    checks++;
    if (bus.in_ready !== 1'b0 || dbg_state !== 2'd2) begin
      errors++; $display("FAIL zp_flush got in_ready=%b st=%0d exp 0 2", bus.in_ready, dbg_state);
    end
    send(8'd33, 1'b1, st);
    repeat (4) @(posedge clk);
    #1;
    exp_q.push_back({1'b1, 8'd0, 8'd33, 8'd0});
    checks++;
    if (got_q.size() !== 4) begin
      errors++; $display("FAIL zp_count got %0d exp 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      checks++;
      if (g !== exp_q[i]) begin
        errors++; $display("FAIL zp_win%0d got %h exp %h", i, g, exp_q[i]);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
`ifndef MEDWIN_ZERO_PAD_EN
    test_line();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
`else
    test_zero_pad();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
